// File: rtl/ysyx_22041211_axi_master_pkg.sv
// Shared encodings for the AXI4-Lite initiator: FSM states, AXI resp codes, strobe width.
package ysyx_22041211_axi_master_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RADDR = 3'd1;
  localparam logic [2:0] ST_RDATA = 3'd2;
  localparam logic [2:0] ST_WREQ  = 3'd3;
  localparam logic [2:0] ST_WRESP = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int strb_w(input int data_len);
    return data_len / 8;
  endfunction

endpackage

// File: rtl/ysyx_22041211_axi_master.sv
// Single-outstanding AXI4-Lite initiator: one core request in, one AR/R or AW/W/B
// transaction out, one registered completion pulse back.
module ysyx_22041211_axi_master
  import ysyx_22041211_axi_master_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_wen_i,
  input  logic [ADDR_LEN-1:0]           req_addr_i,
  input  logic [DATA_LEN-1:0]           req_wdata_i,
  input  logic [strb_w(DATA_LEN)-1:0]   req_wmask_i,
  output logic                          resp_valid_o,
  output logic [DATA_LEN-1:0]           resp_rdata_o,
  output logic                          resp_err_o,
  output logic [ADDR_LEN-1:0]           addr_r_addr_o,
  output logic                          addr_r_valid_o,
  input  logic                          addr_r_ready_i,
  input  logic [DATA_LEN-1:0]           r_data_i,
  input  logic [1:0]                    r_resp_i,
  input  logic                          r_valid_i,
  output logic                          r_ready_o,
  output logic [ADDR_LEN-1:0]           addr_w_addr_o,
  output logic                          addr_w_valid_o,
  input  logic                          addr_w_ready_i,
  output logic [DATA_LEN-1:0]           w_data_o,
  output logic [strb_w(DATA_LEN)-1:0]   w_strb_o,
  output logic                          w_valid_o,
  input  logic                          w_ready_i,
  input  logic [1:0]                    bkwd_resp_i,
  input  logic                          bkwd_valid_i,
  output logic                          bkwd_ready_o
);

  logic [2:0]                  r_state;
  logic                        r_wen;
  logic [ADDR_LEN-1:0]         r_addr;
  logic [DATA_LEN-1:0]         r_wdata;
  logic [strb_w(DATA_LEN)-1:0] r_wmask;
  logic                        r_aw_done;
  logic                        r_w_done;
  logic                        r_resp_valid;
  logic [DATA_LEN-1:0]         r_rdata;
  logic                        r_err;

  logic w_aw_hs;
  logic w_w_hs;

  // Channel outputs come only from state and holding registers, so they are
  // stable for the whole time a valid waits on its ready.
  assign req_ready_o    = (r_state == ST_IDLE) && !rst;
  assign addr_r_valid_o = (r_state == ST_RADDR) && !r_wen;
  assign r_ready_o      = (r_state == ST_RDATA) && !r_wen;
  assign addr_w_valid_o = (r_state == ST_WREQ) && r_wen && !r_aw_done;
  assign w_valid_o      = (r_state == ST_WREQ) && r_wen && !r_w_done;
  assign bkwd_ready_o   = (r_state == ST_WRESP);

  assign addr_r_addr_o = r_addr;
  assign addr_w_addr_o = r_addr;
  assign w_data_o      = r_wdata;
  assign w_strb_o      = r_wmask;

  assign resp_valid_o = r_resp_valid;
  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = r_err;

  assign w_aw_hs = addr_w_valid_o && addr_w_ready_i;
  assign w_w_hs  = w_valid_o && w_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_wen     <= req_wen_i;
            r_addr    <= req_addr_i;
            r_wdata   <= req_wdata_i;
            r_wmask   <= req_wmask_i;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= req_wen_i ? ST_WREQ : ST_RADDR;
          end
        end
        ST_RADDR: begin
          if (addr_r_ready_i) r_state <= ST_RDATA;
        end
        ST_RDATA: begin
          if (r_valid_i) begin
            r_rdata      <= r_data_i;
            r_err        <= (r_resp_i != RESP_OKAY);
            r_resp_valid <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        ST_WREQ: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          // Same-cycle completion of the last outstanding channel counts too.
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) r_state <= ST_WRESP;
        end
        ST_WRESP: begin
          if (bkwd_valid_i) begin
            r_err        <= (bkwd_resp_i != RESP_OKAY);
            r_resp_valid <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
